button_step_gen: RTL and testbench
==================================

BUTTON_STEP_GEN -- requirements
Module: button_step_gen

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, the number of consecutive stable cycles required to accept a level change (minimum 2).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, the cycles from the first pulse to the first auto-repeat pulse (minimum 2).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, the cycles between successive auto-repeat pulses (minimum 2).
REQ-004 SHALL have port clk, input, 1 bit, the clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-006 SHALL have port btn_in, input, 1 bit: raw, asynchronous, bouncing push-button level (1 = pressed).
REQ-007 SHALL have port repeat_en, input, 1 bit, the auto-repeat enable, synchronous to clk.
REQ-008 SHALL have port pulse, output, 1 bit: registered single-cycle step strobe, intended to drive the counter's count-enable t.
REQ-009 SHALL have port level, output, 1 bit: registered debounced button level.

Function
REQ-010 SHALL pass btn_in through a 2-flop synchronizer; the FSM sees only the synchronized signal btn_s.
REQ-011 SHALL implement the FSM states IDLE, DEB_PRESS, HELD, REPEAT and DEB_RELEASE, using one shared counter cnt sized by $clog2 of the largest parameter.
REQ-012 In IDLE, btn_s=1 SHALL move the FSM to DEB_PRESS with cnt=0.
REQ-013 In DEB_PRESS, btn_s=0 SHALL return the FSM to IDLE with no pulse (glitch rejected); otherwise cnt increments, and at cnt=DEBOUNCE_CYCLES-1 the FSM SHALL move to HELD with cnt=0, pulse=1 and level=1.
REQ-014 Counting from edge 0 (the first edge that samples btn_in=1), a clean press SHALL assert pulse on edge DEBOUNCE_CYCLES+2.
REQ-015 In HELD, btn_s=0 SHALL move the FSM to DEB_RELEASE with cnt=0; otherwise, with repeat_en=1, cnt=REPEAT_DELAY-1 SHALL move it to REPEAT with cnt=0 and pulse=1.
REQ-016 In HELD, cnt SHALL hold at 0 while repeat_en=0.
REQ-017 In REPEAT, btn_s=0 SHALL move the FSM to DEB_RELEASE; repeat_en=0 SHALL move it to HELD with cnt=0; otherwise cnt=REPEAT_PERIOD-1 SHALL assert pulse and clear cnt.
REQ-018 In DEB_RELEASE, btn_s=1 SHALL return the FSM to HELD with cnt=0 and no pulse (bounce rejected); otherwise at cnt=DEBOUNCE_CYCLES-1 it SHALL move to IDLE with level=0.
REQ-019 pulse SHALL never be high for two consecutive cycles, and SHALL never assert on release.
REQ-020 If btn_s=0 in the same cycle a repeat pulse would fire, the release SHALL take priority: no pulse.
REQ-021 Counters SHALL never wrap; every terminal compare resets cnt explicitly.

Reset
REQ-022 rst=1 SHALL asynchronously force state=IDLE, cnt=0, both synchronizer flops=0, pulse=0 and level=0.
REQ-023 rst asserted mid-press SHALL abort the press; after rst is released, a still-held button SHALL re-debounce from IDLE and produce exactly one new first pulse.

Structure
REQ-024 Package btn_step_pkg SHALL hold the FSM state enum typedef and the default parameter constants.
REQ-025 The synchronizer SHALL be the sub-module sync_2ff (clk, rst, d, q); everything else is flat in button_step_gen.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-026 Clean press, held 20 cycles, repeat_en=0 -> exactly one pulse on edge 6; level=1 from edge 6; level=0 on edge 6 after btn_in falls.
REQ-027 Bounce 1-0-1-0 at 1-cycle spacing, then stable 1 -> no pulse during the bounce; one pulse 6 edges after the last 0-to-1 sample.
REQ-028 repeat_en=1, held 30 cycles -> pulses at edges E, E+8, E+11, E+14, E+17, ...; none after release.
REQ-029 While HELD, a 2-cycle 0 glitch -> level stays 1, no extra pulse, FSM back in HELD.
REQ-030 rst asserted during DEB_PRESS and during REPEAT -> pulse=0, level=0 immediately (asynchronous); one fresh pulse 6 edges after rst deasserts with the button still held.
REQ-031 Bench SHALL chain pulse into the 4-bit counter and check the count equals the number of pulses mod 16.

Source files
------------

// File: rtl/btn_step_pkg.sv
// Shared state encoding and default timing constants for the push-button
// step generator.
package btn_step_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    REPEAT,
    DEB_RELEASE
  } btn_state_e;

  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Sizes the one shared counter to whichever interval is longest.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the raw asynchronous button level into clk.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments so both flops load pre-edge values and
  // the pair really forms a two-stage shift, not a wire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_step_gen.sv
// Debounced push-button to single-cycle step strobe, with optional
// auto-repeat while the button stays held.
module button_step_gen
  import btn_step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic repeat_en,
  output logic pulse,
  output logic level
);

  localparam int CNT_W = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  btn_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             pulse_d;
  logic             level_d;
  logic             btn_s;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pulse <= pulse_d;
      level <= level_d;
    end
  end

  // Every terminal compare clears cnt explicitly, so the counter never wraps.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d = state;
    cnt_d   = cnt;
    pulse_d = 1'b0;
    level_d = level;

    case (state)
      IDLE: begin
        cnt_d = '0;
        if (btn_s) begin
          state_d = DEB_PRESS;
        end
      end

      DEB_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == DEB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          pulse_d = 1'b1;
          level_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      HELD: begin
        if (!btn_s) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end else if (!repeat_en) begin
          cnt_d = '0;
        end else if (cnt == DELAY_LAST) begin
          state_d = REPEAT;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      // Release is tested first so it wins over a repeat pulse due this cycle.
      REPEAT: begin
        if (!btn_s) begin
          state_d = DEB_RELEASE;
          cnt_d   = '0;
        end else if (!repeat_en) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt == PERIOD_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      DEB_RELEASE: begin
        if (btn_s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_step_gen.sv
// Self-checking bench for button_step_gen: vector table, directed corner
// sequences and randomized stimulus against a run-length reference model.
module tb_button_step_gen;
  import btn_step_pkg::*;

  localparam int DEB = 4;
  localparam int RD  = 8;
  localparam int RP  = 3;

  logic       clk;
  logic       rst;
  logic       btn_in;
  logic       repeat_en;
  logic       pulse;
  logic       level;
  logic [3:0] step_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit btn;
    bit ren;
    bit exp_pulse;
    bit exp_level;
  } vec_t;

  vec_t vecs[$];

  button_step_gen #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .repeat_en (repeat_en),
    .pulse     (pulse),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 4-bit counter using pulse as its count enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) step_count <= '0;
    else if (pulse) step_count <= step_count + 4'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a press or release is accepted after DEB+1 consecutive
  // opposite synchronized samples; repeats follow from the length of the
  // uninterrupted held-and-enabled streak.
  bit m_s1, m_s2, m_prev_s, m_level, m_pulse;
  int m_run, m_streak, m_total;

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_prev_s = 0; m_level = 0; m_pulse = 0;
    m_run = 0; m_streak = 0; m_total = 0;
  endtask

  task automatic model_edge(input bit b, input bit en);
    bit s, press_acc, rep;
    s = m_s2;
    press_acc = 0;
    if (m_pulse) m_total++;
    if (m_level && s && m_prev_s && en) m_streak++;
    else m_streak = 0;
    rep = (m_streak >= RD) && (((m_streak - RD) % RP) == 0);
    if (s != m_level) begin
      m_run++;
      if (m_run == DEB + 1) begin
        press_acc = s;
        m_level   = s;
        m_run     = 0;
      end
    end else begin
      m_run = 0;
    end
    m_pulse  = press_acc | rep;
    m_prev_s = s;
    m_s2     = m_s1;
    m_s1     = b;
  endtask

  task automatic tick();
    logic b, en, r;
    b = btn_in; en = repeat_en; r = rst;
    @(posedge clk);
    if (r) model_reset();
    else model_edge(b, en);
    #1;
  endtask

  task automatic run_count(input int n, output int npulse, output int first,
                           output bit lvl_min, output bit lvl_end);
    npulse = 0; first = -1; lvl_min = 1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (pulse === 1'b1) begin
        if (first < 0) first = i;
        npulse++;
      end
      if (level !== 1'b1) lvl_min = 0;
    end
    lvl_end = level;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int np, first, np0, hold;
    bit lmin, lend, found;
    bit bp [5];

    rst = 1'b1; btn_in = 1'b0; repeat_en = 1'b0;
    model_reset();
    #1;
    check("reset_pulse", pulse, 0);
    check("reset_level", level, 0);
    tick(); tick();
    check("reset_count", step_count, 0);
    check("reset_state", dut.state, IDLE);
    rst = 1'b0;

    // Clean press with repeat off, then a 30-cycle hold with repeat on.
    for (int i = 0; i < 28; i++)
      vecs.push_back('{btn: (i < 20), ren: 1'b0, exp_pulse: (i == 6),
                       exp_level: (i >= 6 && i < 26)});
    for (int j = 0; j < 40; j++)
      vecs.push_back('{btn: (j < 30), ren: 1'b1,
                       exp_pulse: (j == 6) || (j >= 14 && j <= 29 && ((j - 14) % 3) == 0),
                       exp_level: (j >= 6 && j < 36)});
    for (int i = 0; i < vecs.size(); i++) begin
      btn_in = vecs[i].btn;
      repeat_en = vecs[i].ren;
      tick();
      check($sformatf("vec%0d_pulse", i), pulse, vecs[i].exp_pulse);
      check($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
    end
    check("table_count", step_count, 8);

    // Bounce 1-0-1-0-1, then stable: single pulse 6 edges after the last rise.
    repeat_en = 1'b0;
    bp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    np0 = 0;
    for (int i = 0; i < 5; i++) begin
      btn_in = bp[i];
      tick();
      if (pulse === 1'b1) np0++;
    end
    run_count(12, np, first, lmin, lend);
    check("bounce_early_pulses", np0, 0);
    check("bounce_pulse_edge", first + 5, 10);
    check("bounce_pulse_count", np, 1);

    // Two-cycle low glitch while held.
    check("glitch_pre_level", level, 1);
    btn_in = 1'b0; tick(); tick();
    btn_in = 1'b1;
    run_count(10, np, first, lmin, lend);
    check("glitch_level_held", lmin, 1);
    check("glitch_pulses", np, 0);
    check("glitch_state", dut.state, HELD);

    // Release: level falls, no pulse.
    btn_in = 1'b0;
    run_count(10, np, first, lmin, lend);
    check("release_pulses", np, 0);
    check("release_level", lend, 0);

    // Reset in the middle of the press debounce.
    btn_in = 1'b1;
    tick(); tick(); tick(); tick();
    check("press_state", dut.state, DEB_PRESS);
    #2 rst = 1'b1;
    #1;
    check("rst_press_pulse", pulse, 0);
    check("rst_press_level", level, 0);
    check("rst_press_state", dut.state, IDLE);
    tick();
    rst = 1'b0;
    run_count(13, np, first, lmin, lend);
    check("rst_press_new_edge", first, 6);
    check("rst_press_new_count", np, 1);

    // Reset while a repeat pulse is on the output.
    repeat_en = 1'b1;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pulse === 1'b1 && dut.state == REPEAT) begin
        found = 1;
        break;
      end
    end
    check("repeat_reached", found, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_repeat_pulse", pulse, 0);
    check("rst_repeat_level", level, 0);
    tick();
    rst = 1'b0;
    repeat_en = 1'b0;
    run_count(13, np, first, lmin, lend);
    check("rst_repeat_new_edge", first, 6);
    check("rst_repeat_new_count", np, 1);
    check("rst_repeat_counter", step_count, 1);
    btn_in = 1'b0;
    run_count(10, np, first, lmin, lend);
    check("pre_random_counter", step_count, m_total % 16);

    // Randomized runs of short bounces and long holds against the model.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        btn_in = ~btn_in;
        hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                           : int'($urandom_range(5, 40));
      end
      hold--;
      if ($urandom_range(0, 39) == 0) repeat_en = ~repeat_en;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 599) == 0) rst = 1'b1;
      tick();
      check("rand_pulse", pulse, m_pulse);
      check("rand_level", level, m_level);
      if ((i % 64) == 63) check("rand_counter", step_count, m_total % 16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
